// File: rtl/sm_1118_adc_pkg.sv
// Constants and types shared by the ADC128S022 controller and this responder.
// Frame layout: 4 leading zero bits, then a 12-bit sample MSB first.
package sm_1118_adc_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int LEAD_ZERO_BITS = 4;
  localparam int ADDR_MSB_EDGE  = 2;
  localparam int ADDR_LSB_EDGE  = 4;

  typedef logic [2:0]  adc_ch_t;
  typedef logic [11:0] adc_sample_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } frame_state_t;

endpackage

// File: rtl/sm_1118_adc_responder_if.sv
// Serial link between the ADC controller (master) and the emulated ADC (slave).
interface sm_1118_adc_responder_if;

  logic adc_sck;
  logic adc_cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output adc_sck, output adc_cs_n, output din, input dout, input dout_oe);
  modport slave  (input adc_sck, input adc_cs_n, input din, output dout, output dout_oe);

endinterface

// File: rtl/sm_1118_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-clk rise/fall pulses
// derived from the synchronized level.
module sm_1118_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/sm_1118_adc_responder.sv
// ADC128S022 slave emulator: decodes the channel address from din and shifts out the
// sample of the channel addressed in the previous frame from a writable sample table.
module sm_1118_adc_responder
  import sm_1118_adc_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int N_CH        = 8,
  parameter int RESET_CH    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  sm_1118_adc_responder_if.slave  adc,
  input  logic                    wr_en,
  input  adc_ch_t                 wr_ch,
  input  logic [DATA_W-1:0]       wr_data,
  output adc_ch_t                 cur_ch,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam logic [3:0] EDGE_MSB  = 4'(ADDR_MSB_EDGE);
  localparam logic [3:0] EDGE_LSB  = 4'(ADDR_LSB_EDGE);
  localparam logic [3:0] EDGE_SNAP = 4'(LEAD_ZERO_BITS);
  localparam logic [3:0] EDGE_LAST = 4'(FRAME_BITS - 1);
  localparam adc_ch_t    RESET_CH_C = 3'(RESET_CH);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_s, din_rise, din_fall;
  logic sync_unused;

  sm_1118_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk_50M), .rst_n(rst_n), .d(adc.adc_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  // chip select idles high, so its synchronizer resets high to avoid a false frame start
  sm_1118_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk_50M), .rst_n(rst_n), .d(adc.adc_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  sm_1118_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk_50M), .rst_n(rst_n), .d(adc.din),
    .level(din_s), .rise(din_rise), .fall(din_fall)
  );

  assign sync_unused = &{1'b0, sck_lvl, cs_lvl, din_rise, din_fall};

  logic [DATA_W-1:0] table_reg [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_table
      always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
          table_reg[gi] <= '0;
        else if (wr_en && (wr_ch == 3'(gi)))
          table_reg[gi] <= wr_data;
      end
    end
  endgenerate

  frame_state_t    state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  adc_ch_t         addr_reg, addr_next;
  adc_ch_t         pend_reg, pend_next;
  adc_ch_t         cur_reg, cur_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [DATA_W-1:0] snap_src;

  // a write landing in the snapshot clk to the channel being converted wins
  always_comb begin
    if (wr_en && (wr_ch == cur_reg) && (int'(wr_ch) < N_CH))
      snap_src = wr_data;
    else if (int'(cur_reg) < N_CH)
      snap_src = table_reg[cur_reg];
    else
      snap_src = '0;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      pend_reg  <= RESET_CH_C;
      cur_reg   <= RESET_CH_C;
      shift_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      pend_reg  <= pend_next;
      cur_reg   <= cur_next;
      shift_reg <= shift_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    pend_next  = pend_reg;
    cur_next   = cur_reg;
    shift_next = shift_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          shift_next = '0;
          if (cnt_reg != 4'd0) begin
            err_next  = 1'b1;
            pend_next = cur_reg;
          end
        end else if (sck_rise) begin
          if ((cnt_reg >= EDGE_MSB) && (cnt_reg <= EDGE_LSB))
            addr_next = {addr_reg[1:0], din_s};
          if (cnt_reg == EDGE_LSB)
            pend_next = {addr_reg[1:0], din_s};
          if (cnt_reg == EDGE_LAST) begin
            cnt_next  = '0;
            cur_next  = pend_reg;
            done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end else if (sck_fall) begin
          // counter already names the bit to drive; the sample enters MSB first at bit 4
          if (cnt_reg == EDGE_SNAP)
            shift_next = {snap_src, {LEAD_ZERO_BITS{1'b0}}};
          else
            shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign adc.dout    = shift_reg[FRAME_BITS-1];
  assign adc.dout_oe = (state_reg == ST_ACTIVE);
  assign cur_ch      = cur_reg;
  assign frame_done  = done_reg;
  assign frame_err   = err_reg;

endmodule

// File: tb/tb_sm_1118_adc_responder.sv
// Directed bench for the ADC128S022 responder: drives SCK/CS/DIN as a controller would
// and compares captured frames and status outputs against hand-computed values.
module tb_sm_1118_adc_responder;

  localparam int HALF = 8;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic [2:0]  cur_ch;
  logic        frame_done;
  logic        frame_err;

  int check_count = 0;
  int pass_count  = 0;
  int done_count  = 0;
  int err_count   = 0;

  sm_1118_adc_responder_if adc_bus();

  sm_1118_adc_responder dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .adc        (adc_bus),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .cur_ch     (cur_ch),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (frame_done === 1'b1) done_count++;
    if (frame_err === 1'b1) err_count++;
  end

  task automatic apply_reset();
    @(negedge clk_50M);
    rst_n = 1'b0;
    repeat (4) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50M);
  endtask

  task automatic tbl_write(input logic [2:0] ch, input logic [11:0] val);
    wr_ch = ch; wr_data = val; wr_en = 1'b1;
    @(negedge clk_50M);
    wr_en = 1'b0;
    @(negedge clk_50M);
  endtask

  task automatic sck_cycle(input logic d, output logic q);
    adc_bus.din = d;
    repeat (HALF) @(negedge clk_50M);
    q = adc_bus.dout;
    adc_bus.adc_sck = 1'b1;
    repeat (HALF) @(negedge clk_50M);
    adc_bus.adc_sck = 1'b0;
  endtask

  // wr_off >= 0 pulses wr_en that many clks after the falling edge following rising edge 3
  task automatic do_frame(input logic [2:0] addr, input int n_rise, input bit start,
                          input bit stop, input int wr_off, input logic [2:0] w_ch,
                          input logic [11:0] w_data, output logic [15:0] data);
    logic d, q;
    data = '0;
    if (start) adc_bus.adc_cs_n = 1'b0;
    for (int k = 0; k < n_rise; k++) begin
      d = (k == 2) ? addr[2] : (k == 3) ? addr[1] : (k == 4) ? addr[0] : 1'b0;
      sck_cycle(d, q);
      data[15-k] = q;
      if (k == 3 && wr_off >= 0) begin
        repeat (wr_off) @(negedge clk_50M);
        wr_ch = w_ch; wr_data = w_data; wr_en = 1'b1;
        @(negedge clk_50M);
        wr_en = 1'b0;
      end
    end
    if (stop) begin
      repeat (HALF) @(negedge clk_50M);
      adc_bus.adc_cs_n = 1'b1;
      repeat (HALF) @(negedge clk_50M);
    end
    $display("frame addr=%0d rises=%0d data=%04h cur_ch=%0d", addr, n_rise, data, cur_ch);
  endtask

  task automatic test_reset();
    adc_bus.adc_sck = 1'b0; adc_bus.adc_cs_n = 1'b1; adc_bus.din = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    check_count++;
    if (adc_bus.dout_oe !== 1'b0) $display("FAIL reset_oe_in_reset: got %b want 0", adc_bus.dout_oe); else pass_count++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    check_count++;
    if (adc_bus.dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", adc_bus.dout); else pass_count++;
    check_count++;
    if (adc_bus.dout_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", adc_bus.dout_oe); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd0) $display("FAIL reset_cur_ch: got %0d want 0", cur_ch); else pass_count++;
    check_count++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else pass_count++;
    check_count++;
    if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else pass_count++;
  endtask

  task automatic test_single_frame();
    logic [15:0] data;
    int d0;
    d0 = done_count;
    do_frame(3'd3, 16, 1'b1, 1'b0, -1, 3'd0, 12'h0, data);
    check_count++;
    if (adc_bus.dout_oe !== 1'b1) $display("FAIL single_oe_active: got %b want 1", adc_bus.dout_oe); else pass_count++;
    repeat (HALF) @(negedge clk_50M);
    adc_bus.adc_cs_n = 1'b1;
    repeat (HALF) @(negedge clk_50M);
    check_count++;
    if (data !== 16'h0000) $display("FAIL single_data: got %04h want 0000", data); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd3) $display("FAIL single_cur_ch: got %0d want 3", cur_ch); else pass_count++;
    check_count++;
    if (done_count - d0 !== 1) $display("FAIL single_done: got %0d want 1", done_count - d0); else pass_count++;
    check_count++;
    if (adc_bus.dout_oe !== 1'b0) $display("FAIL single_oe_idle: got %b want 0", adc_bus.dout_oe); else pass_count++;
  endtask

  task automatic test_table_read();
    logic [15:0] d1, d2;
    int d0;
    tbl_write(3'd3, 12'hA5C);
    d0 = done_count;
    do_frame(3'd3, 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, d1);
    do_frame(3'd3, 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, d2);
    check_count++;
    if (d1 !== 16'h0A5C) $display("FAIL table_first: got %04h want 0a5c", d1); else pass_count++;
    check_count++;
    if (d2 !== 16'h0A5C) $display("FAIL table_second: got %04h want 0a5c", d2); else pass_count++;
    check_count++;
    if (done_count - d0 !== 2) $display("FAIL table_done: got %0d want 2", done_count - d0); else pass_count++;
  endtask

  task automatic test_lag();
    logic [2:0]  addrs [5] = '{3'd1, 3'd3, 3'd4, 3'd1, 3'd3};
    logic [15:0] exp_d [5] = '{16'h0000, 16'h0111, 16'h0333, 16'h0444, 16'h0111};
    logic [15:0] data;
    apply_reset();
    tbl_write(3'd1, 12'h111);
    tbl_write(3'd3, 12'h333);
    tbl_write(3'd4, 12'h444);
    for (int i = 0; i < 5; i++) begin
      do_frame(addrs[i], 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, data);
      check_count++;
      if (data !== exp_d[i]) $display("FAIL lag_frame%0d: got %04h want %04h", i, data, exp_d[i]); else pass_count++;
    end
  endtask

  task automatic test_abort();
    logic [15:0] data;
    int d0, e0;
    d0 = done_count; e0 = err_count;
    do_frame(3'd5, 9, 1'b1, 1'b1, -1, 3'd0, 12'h0, data);
    check_count++;
    if (err_count - e0 !== 1) $display("FAIL abort_err: got %0d want 1", err_count - e0); else pass_count++;
    check_count++;
    if (done_count - d0 !== 0) $display("FAIL abort_done: got %0d want 0", done_count - d0); else pass_count++;
    check_count++;
    if (adc_bus.dout_oe !== 1'b0) $display("FAIL abort_oe: got %b want 0", adc_bus.dout_oe); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd3) $display("FAIL abort_cur_ch: got %0d want 3", cur_ch); else pass_count++;
    do_frame(3'd6, 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, data);
    check_count++;
    if (data !== 16'h0333) $display("FAIL abort_next_data: got %04h want 0333", data); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd6) $display("FAIL abort_next_cur: got %0d want 6", cur_ch); else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] da, db;
    int d0, e0;
    tbl_write(3'd6, 12'h6C1);
    tbl_write(3'd2, 12'h2B7);
    d0 = done_count; e0 = err_count;
    do_frame(3'd2, 16, 1'b1, 1'b0, -1, 3'd0, 12'h0, da);
    do_frame(3'd5, 16, 1'b0, 1'b1, -1, 3'd0, 12'h0, db);
    check_count++;
    if (da !== 16'h06C1) $display("FAIL cont_first: got %04h want 06c1", da); else pass_count++;
    check_count++;
    if (db !== 16'h02B7) $display("FAIL cont_second: got %04h want 02b7", db); else pass_count++;
    check_count++;
    if (done_count - d0 !== 2) $display("FAIL cont_done: got %0d want 2", done_count - d0); else pass_count++;
    check_count++;
    if (err_count - e0 !== 0) $display("FAIL cont_err: got %0d want 0", err_count - e0); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd5) $display("FAIL cont_cur_ch: got %0d want 5", cur_ch); else pass_count++;
  endtask

  task automatic test_write_bypass();
    logic [15:0] data;
    do_frame(3'd5, 16, 1'b1, 1'b1, 2, 3'd5, 12'h9A6, data);
    check_count++;
    if (data !== 16'h09A6) $display("FAIL bypass_same_clk: got %04h want 09a6", data); else pass_count++;
    do_frame(3'd5, 16, 1'b1, 1'b1, 3, 3'd5, 12'h3C3, data);
    check_count++;
    if (data !== 16'h09A6) $display("FAIL bypass_late_write: got %04h want 09a6", data); else pass_count++;
    do_frame(3'd5, 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, data);
    check_count++;
    if (data !== 16'h03C3) $display("FAIL bypass_next_frame: got %04h want 03c3", data); else pass_count++;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] data;
    do_frame(3'd7, 8, 1'b1, 1'b0, -1, 3'd0, 12'h0, data);
    repeat (HALF) @(negedge clk_50M);
    check_count++;
    if (adc_bus.dout !== 1'b1) $display("FAIL midrst_pre_dout: got %b want 1", adc_bus.dout); else pass_count++;
    rst_n = 1'b0;
    @(negedge clk_50M);
    check_count++;
    if (adc_bus.dout !== 1'b0) $display("FAIL midrst_dout: got %b want 0", adc_bus.dout); else pass_count++;
    check_count++;
    if (adc_bus.dout_oe !== 1'b0) $display("FAIL midrst_oe: got %b want 0", adc_bus.dout_oe); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd0) $display("FAIL midrst_cur_ch: got %0d want 0", cur_ch); else pass_count++;
    adc_bus.adc_cs_n = 1'b1;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk_50M);
    tbl_write(3'd0, 12'h123);
    do_frame(3'd2, 16, 1'b1, 1'b1, -1, 3'd0, 12'h0, data);
    check_count++;
    if (data !== 16'h0123) $display("FAIL midrst_next_data: got %04h want 0123", data); else pass_count++;
    check_count++;
    if (cur_ch !== 3'd2) $display("FAIL midrst_next_cur: got %0d want 2", cur_ch); else pass_count++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_table_read();
    test_lag();
    test_abort();
    test_back_to_back();
    test_write_bypass();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
